// File: rtl/ws2812_frame_scheduler_if.sv
// ----------------------------------------------------------------------------
// ws2812_frame_scheduler_if
//
// Groups the two buses around the frame scheduler: the synchronous pixel buffer
// read port and the load/done link to the WS2812 bit-serializer.
//
// Signals
//   pix_addr  ADDR_W  pixel buffer read address (scheduler -> buffer)
//   pix_data  24      pixel buffer read data, valid the cycle after pix_addr
//   ser_load  1       one-cycle pulse: serializer takes ser_data and starts
//   ser_data  24      colour word, stable from ser_load until ser_done
//   ser_done  1       one-cycle pulse: serializer has sent all 24 bits
//
// Handshake: ser_load and ser_done are single-cycle pulses, not levels. After
// the scheduler pulses ser_load it keeps ser_data unchanged and issues no
// further ser_load until it has seen ser_done. A ser_done that arrives while
// the scheduler is not waiting for one carries no meaning and is dropped.
//
// Modports
//   master  scheduler side (drives address and serializer load)
//   slave   buffer/serializer side
// ----------------------------------------------------------------------------
interface ws2812_frame_scheduler_if #(
  parameter int ADDR_W = 6
) ();
  logic [ADDR_W-1:0] pix_addr;
  logic [23:0]       pix_data;
  logic              ser_load;
  logic [23:0]       ser_data;
  logic              ser_done;

  modport master (
    output pix_addr,
    input  pix_data,
    output ser_load,
    output ser_data,
    input  ser_done
  );

  modport slave (
    input  pix_addr,
    output pix_data,
    input  ser_load,
    input  ser_data,
    output ser_done
  );
endinterface

// File: rtl/ws2812_frame_scheduler.sv
// ----------------------------------------------------------------------------
// ws2812_frame_scheduler
//
// Walks one frame of NUM_LEDS pixels out of a synchronous pixel buffer into the
// WS2812 serializer, one 24-bit word at a time, then holds the line in the
// latch (reset) interval and pulses frame_done. A start that arrives while a
// frame is running is remembered (one deep) and replayed after the frame.
//
// Ports
//   clk         in   system clock
//   reset       in   synchronous, active-high reset; aborts any frame
//   start       in   single-cycle frame request
//   bus         --   pixel buffer + serializer handshake (master modport)
//   latch       out  high during the latch interval (line forced low)
//   busy        out  high in every state except IDLE
//   frame_done  out  one-cycle pulse at the end of a frame
//   error       out  sticky serializer-timeout flag, cleared only by reset
//   dbg_state   out  current FSM state encoding
// ----------------------------------------------------------------------------
module ws2812_frame_scheduler #(
  parameter int NUM_LEDS       = 64,
  parameter int ADDR_W         = 6,
  parameter int LATCH_CYCLES   = 2400,
  parameter int TIMEOUT_CYCLES = 2047
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  ws2812_frame_scheduler_if.master    bus,
  output logic                        latch,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        error,
  output logic [2:0]                  dbg_state
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LW = $clog2(LATCH_CYCLES + 1);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_LEDS - 1);
  localparam logic [TW-1:0]     T_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [LW-1:0]     L_LAST   = LW'(LATCH_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_WAIT  = 3'd3,
    S_LATCH = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] pix_addr_q;
  logic              ser_load_q;
  logic [23:0]       ser_data_q;
  logic              pending;
  logic [TW-1:0]     tcnt;
  logic [LW-1:0]     lcnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      pix_addr_q <= '0;
      ser_load_q <= 1'b0;
      ser_data_q <= '0;
      pending    <= 1'b0;
      tcnt       <= '0;
      lcnt       <= '0;
      latch      <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      error      <= 1'b0;
    end else begin
      // Pulse outputs default low; the states below raise them for one cycle.
      ser_load_q <= 1'b0;
      frame_done <= 1'b0;

      // Any start outside IDLE (including the DONE cycle) queues one frame;
      // extra starts fold into the same pending flag.
      if (start && (state != S_IDLE)) begin
        pending <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (start || pending) begin
            pending    <= 1'b0;
            idx        <= '0;
            pix_addr_q <= '0;
            busy       <= 1'b1;
            state      <= S_FETCH;
          end
        end

        S_FETCH: begin
          // Address is on the buffer this cycle; its data arrives in LOAD.
          ser_load_q <= 1'b1;
          state      <= S_LOAD;
        end

        S_LOAD: begin
          // Buffer address is unchanged, so the word present now is the one
          // shown to the serializer through the bypass below.
          ser_data_q <= bus.pix_data;
          tcnt       <= '0;
          state      <= S_WAIT;
        end

        S_WAIT: begin
          // ser_done is tested first so that it wins over a coincident
          // timeout expiry.
          if (bus.ser_done) begin
            if (idx == LAST_IDX) begin
              latch <= 1'b1;
              lcnt  <= '0;
              state <= S_LATCH;
            end else begin
              idx        <= idx + 1'b1;
              pix_addr_q <= idx + 1'b1;
              state      <= S_FETCH;
            end
          end else if (tcnt == T_LAST) begin
            // Serializer silent for TIMEOUT_CYCLES: drop the rest of the
            // frame but still run the latch interval so the strip settles.
            error <= 1'b1;
            latch <= 1'b1;
            lcnt  <= '0;
            state <= S_LATCH;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        S_LATCH: begin
          if (lcnt == L_LAST) begin
            latch      <= 1'b0;
            frame_done <= 1'b1;
            state      <= S_DONE;
          end else begin
            lcnt <= lcnt + 1'b1;
          end
        end

        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.pix_addr = pix_addr_q;
  assign bus.ser_load = ser_load_q;
  // The buffer answers one cycle after the address, i.e. during LOAD, which
  // is also the ser_load cycle. Pass the read data straight through in LOAD
  // and hold the captured copy for the rest of the pixel.
  assign bus.ser_data = (state == S_LOAD) ? bus.pix_data : ser_data_q;
  assign dbg_state    = state;

endmodule

// File: doc/ws2812_frame_scheduler.md
Name: ws2812_frame_scheduler

Overview:
- Sequences one full frame of pixel colours into the WS2812 bit-serializer, which takes 24-bit colour data and pulses done once all 24 bits are sent.
- Fetches each pixel word from a synchronous pixel buffer, hands it to the serializer with a load/done handshake, then holds the line low for the latch interval and signals frame completion.
- Sits between the face-rendering logic, which fills the buffer and pulses start, and the serializer.

Parameters:
- NUM_LEDS, 64: pixels per frame.
- ADDR_W, 6: pixel buffer address width; must satisfy 2^ADDR_W >= NUM_LEDS.
- LATCH_CYCLES, 2400: clk cycles the line is held low after the last pixel (60 us at 40 MHz).
- TIMEOUT_CYCLES, 2047: maximum cycles to wait for ser_done before aborting.

Ports:
- clk  in  1  system clock (40 MHz).
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to send a frame.
- pix_addr  out  ADDR_W  pixel buffer read address.
- pix_data  in  24  pixel buffer read data; valid exactly 1 cycle after pix_addr.
- ser_load  out  1  one-cycle pulse: serializer latches ser_data and begins sending.
- ser_data  out  24  colour word for the serializer; held stable from ser_load until ser_done.
- ser_done  in  1  one-cycle pulse from the serializer: 24 bits sent.
- latch  out  1  high during the latch/reset interval; the top level forces datastream low while latch is high.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse at the end of a frame.
- error  out  1  sticky flag set on serializer timeout.

Behaviour:
- Reset values: pix_addr=0, ser_load=0, ser_data=0, latch=0, busy=0, frame_done=0, error=0, pending=0, all counters 0. FSM enters IDLE. Reset is honoured in any state and aborts a frame mid-operation; no frame_done is issued for the aborted frame.
- FSM states: IDLE, FETCH, LOAD, WAIT, LATCH, DONE.
- IDLE:
  - start=1 -> FETCH, with pix_addr=0 and pixel index idx=0.
  - Otherwise, if pending=1 -> clear pending and go to FETCH.
- FETCH (1 cycle): pix_addr=idx is presented. Next cycle -> LOAD, with pix_data captured into ser_data.
- LOAD (1 cycle): ser_load=1. -> WAIT, with the timeout counter cleared.
- WAIT: the timeout counter increments each cycle.
  - ser_done=1: if idx==NUM_LEDS-1 -> LATCH; else idx+1 -> FETCH.
  - Counter reaches TIMEOUT_CYCLES with no ser_done: set error=1 -> LATCH (frame abandoned).
- LATCH: latch=1; count LATCH_CYCLES cycles. After the final count -> DONE.
- DONE (1 cycle): frame_done=1. -> IDLE.
- Per-pixel overhead: 3 cycles (FETCH, LOAD, WAIT entry) plus the serializer time.
  - start-to-first ser_load latency = 2 cycles (start sampled at edge 0, FETCH at cycle 1, ser_load high at cycle 2).
- start while busy: sets pending=1 (one deep; further starts are absorbed). A pending frame begins on the cycle after DONE via IDLE, i.e. 1 idle cycle between frames.
- start in the same cycle as frame_done: sets pending.
- ser_done outside WAIT: ignored. ser_done in the same cycle as timeout expiry: ser_done wins; error is not set.
- idx has ADDR_W bits and never wraps past NUM_LEDS-1. pix_addr holds its last value outside FETCH.
- error clears only on reset.

Test Plan:
- Normal frame with NUM_LEDS=4, LATCH_CYCLES=10, buffer={24'h00b000,24'h00f060,24'h00b0b0,24'h0000b0}, serializer model answering ser_done 30 cycles after ser_load -> exactly 4 ser_load pulses with ser_data in buffer order; latch high for 10 cycles; one frame_done; busy drops the cycle after frame_done.
- Latency check -> start at cycle 0 gives ser_load at cycle 2 with ser_data=24'h00b000; pix_addr=0 at cycle 1.
- start pulsed 3 times mid-frame -> exactly one extra frame follows, first ser_load 3 cycles after the first frame_done; 2 frame_done pulses total.
- Serializer never answers on pixel 1 with TIMEOUT_CYCLES=50 -> error=1 after 50 WAIT cycles; latch interval runs; frame_done pulses; error stays 1 until reset.
- Reset asserted in WAIT of pixel 2 -> next cycle all outputs are at reset values with no frame_done; a new start runs a full frame from pix_addr=0.
- Spurious ser_done in IDLE and LATCH, plus ser_done coincident with timeout expiry -> no state change from the spurious pulses; the coincident one advances idx and error stays 0.
